// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA write arbiter: default screen bounds, pixel
// field widths, requester index constants, FSM state encoding, the pixel
// record carried through the arbiter, and one-hot/index helpers.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned SCREEN_W_DEF = 320;
    localparam int unsigned SCREEN_H_DEF = 240;

    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COLOR_W = 9;   // RGB 3:3:3
    localparam int N_REQ   = 3;

    // Requester indices; OWNER_NONE marks "no burst owner".
    localparam logic [1:0] REQ_CLEAR  = 2'd0;
    localparam logic [1:0] REQ_BRUSH  = 2'd1;
    localparam logic [1:0] REQ_CURSOR = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

    // FSM state encoding.
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    // Requester index to one-hot; OWNER_NONE maps to all zeros.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        case (idx)
            REQ_CLEAR:  oh = 3'b001;
            REQ_BRUSH:  oh = 3'b010;
            REQ_CURSOR: oh = 3'b100;
            default:    oh = '0;
        endcase
        return oh;
    endfunction

    // One-hot (or zero) to requester index; zero maps to OWNER_NONE.
    function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [1:0] idx;
        idx = OWNER_NONE;
        if (oh[0])      idx = REQ_CLEAR;
        else if (oh[1]) idx = REQ_BRUSH;
        else if (oh[2]) idx = REQ_CURSOR;
        return idx;
    endfunction

endpackage

// File: rtl/vga_arb_pick.sv
// ----------------------------------------------------------------------------
// vga_arb_pick
// Combinational 3-way pick: searches valid_i starting at start_i and wrapping
// modulo 3, returning a one-hot grant of the first valid requester found.
// A start index of 3 is treated as 0.
//
// Ports
//   valid_i  in  3  per-requester valid
//   start_i  in  2  index where the search begins
//   grant_o  out 3  one-hot grant (zero when nothing is valid)
// ----------------------------------------------------------------------------
module vga_arb_pick
    import vga_pkg::*;
(
    input  logic [N_REQ-1:0] valid_i,
    input  logic [1:0]       start_i,
    output logic [N_REQ-1:0] grant_o
);

    // NOTE: every output gets a default before the branches, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        case (start_i)
            REQ_BRUSH: begin
                if (valid_i[1])      grant_o = 3'b010;
                else if (valid_i[2]) grant_o = 3'b100;
                else if (valid_i[0]) grant_o = 3'b001;
            end
            REQ_CURSOR: begin
                if (valid_i[2])      grant_o = 3'b100;
                else if (valid_i[0]) grant_o = 3'b001;
                else if (valid_i[1]) grant_o = 3'b010;
            end
            default: begin
                if (valid_i[0])      grant_o = 3'b001;
                else if (valid_i[1]) grant_o = 3'b010;
                else if (valid_i[2]) grant_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// ----------------------------------------------------------------------------
// vga_write_arbiter
// Arbitrates three pixel requesters (clear engine, brush, cursor renderer)
// onto one VGA adapter write port. A burst that does not end on its first
// beat locks the port to its owner until a beat with req_last is accepted.
// Accepted in-range beats are written one cycle later; out-of-range beats
// complete the handshake but are dropped.
//
// Configuration
//   VGA_ARB_ROUND_ROBIN_EN  defined: round-robin IDLE arbitration
//                           undefined: fixed priority 0 > 1 > 2
//
// Ports
//   CLOCK_50   in  1   clock, rising edge
//   reset      in  1   asynchronous active-high reset
//   req_valid  in  3   per-requester pixel valid
//   req_last   in  3   per-requester end-of-burst marker
//   req_x      in  27  packed 3x9 pixel x
//   req_y      in  24  packed 3x8 pixel y
//   req_color  in  27  packed 3x9 colour
//   req_ready  out 3   per-requester accept (at most one high)
//   vga_x      out 9   registered pixel x
//   vga_y      out 8   registered pixel y
//   vga_color  out 9   registered colour
//   vga_write  out 1   registered write strobe
//   owner      out 2   current burst owner, 3 = none
//   busy       out 1   high while a burst is locked
// ----------------------------------------------------------------------------
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*COLOR_W-1:0] req_color,
    output logic [N_REQ-1:0]       req_ready,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COLOR_W-1:0]     vga_color,
    output logic                   vga_write,
    output logic [1:0]             owner,
    output logic                   busy
);

    logic             state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    pixel_t           pix_q, pix_d;
    logic             write_q, write_d;

    logic [N_REQ-1:0] pick_grant;
    logic [1:0]       pick_start;
    logic [N_REQ-1:0] fire;
    logic             xfer;
    logic [1:0]       sel_idx;
    pixel_t           beat;
    logic             beat_last;
    logic             in_range;

    // ------------------------------------------------------------------
    // Search start for the IDLE pick.
    // ------------------------------------------------------------------
`ifdef VGA_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Start one past the last IDLE grant, wrapping 2 -> 0.
    always_comb begin
        pick_start = (rr_ptr_q == REQ_CURSOR) ? REQ_CLEAR : rr_ptr_q + 2'd1;
    end

    // Pointer follows every IDLE grant; grants inside a locked burst do not
    // move it.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE && xfer) begin
            rr_ptr_d = sel_idx;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= REQ_CURSOR;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_start = REQ_CLEAR;
`endif

    vga_arb_pick u_pick (
        .valid_i (req_valid),
        .start_i (pick_start),
        .grant_o (pick_grant)
    );

    // ------------------------------------------------------------------
    // Handshake: in LOCKED only the owner may be accepted, even if it is
    // currently idle and others are waiting.
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == ST_LOCKED) begin
            req_ready = idx_to_onehot(owner_q) & req_valid;
        end else begin
            req_ready = pick_grant;
        end
    end

    assign fire    = req_valid & req_ready;
    assign xfer    = |fire;
    assign sel_idx = onehot_to_idx(fire);

    // Select the accepted beat; fire is one-hot or zero.
    always_comb begin
        beat      = '0;
        beat_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fire[i]) begin
                beat.x     = req_x[X_W*i +: X_W];
                beat.y     = req_y[Y_W*i +: Y_W];
                beat.color = req_color[COLOR_W*i +: COLOR_W];
                beat_last  = req_last[i];
            end
        end
    end

    assign in_range = (32'(beat.x) < SCREEN_W) && (32'(beat.y) < SCREEN_H);

    // ------------------------------------------------------------------
    // Burst lock FSM. A single-beat burst in IDLE never locks.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                if (!beat_last) begin
                    state_d = ST_LOCKED;
                    owner_d = sel_idx;
                end
            end else if (beat_last) begin
                state_d = ST_IDLE;
                owner_d = OWNER_NONE;
            end
        end
    end

    // Out-of-range beats are consumed without touching the pixel register.
    assign write_d = xfer && in_range;
    assign pix_d   = write_d ? beat : pix_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_NONE;
            pix_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pix_q   <= pix_d;
            write_q <= write_d;
        end
    end

    assign vga_x     = pix_q.x;
    assign vga_y     = pix_q.y;
    assign vga_color = pix_q.color;
    assign vga_write = write_q;
    assign owner     = owner_q;
    assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_write_arbiter
// Self-checking bench for vga_write_arbiter: a table of hand-derived vectors,
// directed multi-cycle sequences (burst lock, long clear burst, reset during
// a burst, arbitration order) and randomized traffic compared against a
// behavioural model of the arbitration and write rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_write_arbiter;

    localparam int SW = 320;
    localparam int SH = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_last;
    logic [26:0] req_x;
    logic [23:0] req_y;
    logic [26:0] req_color;
    logic [2:0]  req_ready;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [8:0]  vga_color;
    logic        vga_write;
    logic [1:0]  owner;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_write_arbiter #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .req_ready (req_ready),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_write (vga_write),
        .owner     (owner),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    bit m_locked;
    int m_owner;
    int m_ptr;
    bit m_vw;
    int m_vx, m_vy, m_vc;
    bit count_en;
    int wr_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 3;
        m_ptr    = 2;
        m_vw     = 0;
        m_vx     = 0;
        m_vy     = 0;
        m_vc     = 0;
    endtask

    // Which requester the rules say is accepted this cycle (-1 = none).
    function automatic int model_grant(input logic [2:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
`ifdef VGA_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 3; k++) begin
            if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
`else
        for (int k = 0; k < 3; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic model_edge(input int g);
        int bx, by, bc;
        bit bl;
        if (g >= 0) begin
            bx = int'(req_x[9*g +: 9]);
            by = int'(req_y[8*g +: 8]);
            bc = int'(req_color[9*g +: 9]);
            bl = req_last[g];
            if (bx < SW && by < SH) begin
                m_vw = 1; m_vx = bx; m_vy = by; m_vc = bc;
            end else begin
                m_vw = 0;
            end
            if (!m_locked) begin
                m_ptr = g;
                if (!bl) begin
                    m_locked = 1;
                    m_owner  = g;
                end
            end else if (bl) begin
                m_locked = 0;
                m_owner  = 3;
            end
        end else begin
            m_vw = 0;
        end
    endtask

    // Inputs already applied (posedge+1); compare at negedge, advance model.
    task automatic step(input string name);
        int g;
        logic [2:0]  exp_rdy;
        logic [32:0] got, exp;
        @(negedge clk);
        g = model_grant(req_valid);
        exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
        exp = {exp_rdy, 2'(m_owner), m_locked, m_vw, 9'(m_vx), 8'(m_vy), 9'(m_vc)};
        got = {req_ready, owner, busy, vga_write, vga_x, vga_y, vga_color};
        check(name, 64'(got), 64'(exp));
        if (count_en && vga_write) wr_cnt++;
        @(posedge clk);
        model_edge(g);
        #1;
    endtask

    function automatic logic [26:0] pk9(input int a, input int b, input int c);
        return {9'(c), 9'(b), 9'(a)};
    endfunction

    function automatic logic [23:0] pk8(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic idle_inputs();
        req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_color = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        count_en = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  v;
        logic [2:0]  l;
        logic [26:0] x;
        logic [23:0] y;
        logic [26:0] c;
        logic [2:0]  e_rdy;
        logic [1:0]  e_own;
        logic        e_busy;
        logic        e_vw;
        logic [8:0]  e_vx;
        logic [7:0]  e_vy;
        logic [8:0]  e_vc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [32:0] got, exp;
        logic [2:0]  exp_oh;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        count_en = 0;
        wr_cnt = 0;

        // Reset state while reset is held.
        #2;
        check("reset_state", 64'({req_ready, owner, busy, vga_write, vga_x, vga_y, vga_color}),
              64'({3'b000, 2'd3, 1'b0, 1'b0, 9'd0, 8'd0, 9'd0}));

        // Rows 0-3: req 1 and 2 single beats together; rows 4-7: out-of-range
        // then corner pixel; rows 8-14: req 0 burst with req 2 waiting.
        tbl[0]  = '{3'b110, 3'b111, pk9(0,10,30), pk8(0,20,40), pk9(0,'h1A5,'h0F0), 3'b010, 2'd3, 1'b0, 1'b0, 9'd0,   8'd0,   9'h000};
        tbl[1]  = '{3'b100, 3'b111, pk9(0,10,30), pk8(0,20,40), pk9(0,'h1A5,'h0F0), 3'b100, 2'd3, 1'b0, 1'b1, 9'd10,  8'd20,  9'h1A5};
        tbl[2]  = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b1, 9'd30,  8'd40,  9'h0F0};
        tbl[3]  = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b0, 9'd30,  8'd40,  9'h0F0};
        tbl[4]  = '{3'b010, 3'b111, pk9(0,320,0), pk8(0,5,0),   pk9(0,'h0AA,0),     3'b010, 2'd3, 1'b0, 1'b0, 9'd30,  8'd40,  9'h0F0};
        tbl[5]  = '{3'b010, 3'b111, pk9(0,319,0), pk8(0,239,0), pk9(0,'h155,0),     3'b010, 2'd3, 1'b0, 1'b0, 9'd30,  8'd40,  9'h0F0};
        tbl[6]  = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b1, 9'd319, 8'd239, 9'h155};
        tbl[7]  = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b0, 9'd319, 8'd239, 9'h155};
        tbl[8]  = '{3'b001, 3'b000, pk9(1,0,0),   pk8(1,0,0),   pk9(7,0,0),         3'b001, 2'd3, 1'b0, 1'b0, 9'd319, 8'd239, 9'h155};
        tbl[9]  = '{3'b101, 3'b100, pk9(2,0,5),   pk8(1,0,6),   pk9(8,0,'h1FF),     3'b001, 2'd0, 1'b1, 1'b1, 9'd1,   8'd1,   9'h007};
        tbl[10] = '{3'b100, 3'b100, pk9(2,0,5),   pk8(1,0,6),   pk9(8,0,'h1FF),     3'b000, 2'd0, 1'b1, 1'b1, 9'd2,   8'd1,   9'h008};
        tbl[11] = '{3'b101, 3'b101, pk9(3,0,5),   pk8(1,0,6),   pk9(9,0,'h1FF),     3'b001, 2'd0, 1'b1, 1'b0, 9'd2,   8'd1,   9'h008};
        tbl[12] = '{3'b100, 3'b100, pk9(3,0,5),   pk8(1,0,6),   pk9(9,0,'h1FF),     3'b100, 2'd3, 1'b0, 1'b1, 9'd3,   8'd1,   9'h009};
        tbl[13] = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b1, 9'd5,   8'd6,   9'h1FF};
        tbl[14] = '{3'b000, 3'b000, pk9(0,0,0),   pk8(0,0,0),   pk9(0,0,0),         3'b000, 2'd3, 1'b0, 1'b0, 9'd5,   8'd6,   9'h1FF};

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            req_x     = tbl[i].x;
            req_y     = tbl[i].y;
            req_color = tbl[i].c;
            @(negedge clk);
            got = {req_ready, owner, busy, vga_write, vga_x, vga_y, vga_color};
            exp = {tbl[i].e_rdy, tbl[i].e_own, tbl[i].e_busy, tbl[i].e_vw,
                   tbl[i].e_vx, tbl[i].e_vy, tbl[i].e_vc};
            check($sformatf("vec[%0d]", i), 64'(got), 64'(exp));
            @(posedge clk);
            #1;
        end

        // ---------- owner 2 drops valid mid-burst, req 0 must wait ----------
        do_reset();
        req_x = pk9(11,0,50); req_y = pk8(12,0,60); req_color = pk9('h111,0,'h0C3);
        req_valid = 3'b100; req_last = 3'b000; step("drop_lock");
        req_valid = 3'b101;                    step("drop_beat2");
        req_valid = 3'b001;
        for (int k = 0; k < 5; k++) begin
            #3;
            check($sformatf("drop_wait_ready[%0d]", k), 64'(req_ready), 64'(3'b000));
            check($sformatf("drop_wait_owner[%0d]", k), 64'(owner), 64'(2'd2));
            step("drop_wait");
        end
        req_valid = 3'b101; req_last = 3'b101; step("drop_last");
        req_valid = 3'b001;                    step("drop_handoff");
        idle_inputs();                         step("drop_idle");
        step("drop_idle2");

        // ---------- full-screen clear burst with cursor waiting ----------
        do_reset();
        count_en = 1;
        wr_cnt = 0;
        for (int i = 0; i < SW*SH; i++) begin
            req_valid = 3'b101;
            req_last  = {1'b1, 1'b0, (i == SW*SH - 1)};
            req_x     = pk9(i % SW, 0, 400);
            req_y     = pk8(i / SW, 0, 7);
            req_color = pk9(i % 512, 0, 3);
            step("clear");
        end
        req_valid = 3'b100;
        #3;
        check("clear_handoff_ready", 64'(req_ready), 64'(3'b100));
        check("clear_handoff_busy", 64'({owner, busy}), 64'({2'd3, 1'b0}));
        step("clear_handoff");
        idle_inputs();
        step("clear_tail");
        count_en = 0;
        check("clear_write_count", 64'(wr_cnt), 64'(SW*SH));

        // ---------- reset asserted during LOCKED ----------
        do_reset();
        req_valid = 3'b010; req_last = 3'b000;
        req_x = pk9(0,100,0); req_y = pk8(0,50,0); req_color = pk9(0,'h07F,0);
        step("rst_accept");
        req_x = pk9(0,101,0);
        step("rst_beat2");
        check("rst_pre_write", 64'({vga_write, busy}), 64'({1'b1, 1'b1}));
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", 64'({vga_write, owner, busy, vga_x, vga_y, vga_color}),
              64'({1'b0, 2'd3, 1'b0, 9'd0, 8'd0, 9'd0}));
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step("rst_post");
        req_valid = 3'b010; req_last = 3'b010; req_x = pk9(0,7,0); req_y = pk8(0,8,0);
        step("rst_restart");
        idle_inputs();
        step("rst_restart_wr");

        // ---------- all three sending single beats continuously ----------
        do_reset();
        req_valid = 3'b111; req_last = 3'b111;
        req_x = pk9(1,2,3); req_y = pk8(4,5,6); req_color = pk9(7,8,9);
        for (int k = 0; k < 6; k++) begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
            exp_oh = 3'(1 << (k % 3));
`else
            exp_oh = 3'b001;
`endif
            @(negedge clk);
            check($sformatf("arb_order[%0d]", k), 64'(req_ready), 64'(exp_oh));
            @(posedge clk);
            #1;
        end

        // ---------- randomized traffic vs model ----------
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            for (int r = 0; r < 3; r++) begin
                req_valid[r] = ($urandom_range(0, 3) != 0);
                req_last[r]  = ($urandom_range(0, 3) == 0);
                req_x[9*r +: 9]     = 9'($urandom_range(0, 340));
                req_y[8*r +: 8]     = 8'($urandom_range(0, 250));
                req_color[9*r +: 9] = 9'($urandom_range(0, 511));
            end
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 The module SHALL have parameter SCREEN_W, default 320: the exclusive upper bound on pixel x.
REQ-002 The module SHALL have parameter SCREEN_H, default 240: the exclusive upper bound on pixel y.
REQ-003 The module SHALL have port CLOCK_50  in  1  the only clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port req_valid  in  3  per-requester pixel valid (0 = clear engine, 1 = brush, 2 = cursor renderer).
REQ-006 The module SHALL have port req_last  in  3  per-requester end-of-burst marker, qualified by req_valid.
REQ-007 The module SHALL have port req_x  in  27  packed 3x9 pixel x; requester i uses bits [9i+8:9i].
REQ-008 The module SHALL have port req_y  in  24  packed 3x8 pixel y; requester i uses bits [8i+7:8i].
REQ-009 The module SHALL have port req_color  in  27  packed 3x9 colour, RGB 3:3:3.
REQ-010 The module SHALL have port req_ready  out  3  per-requester accept; at most one bit is high.
REQ-011 The module SHALL have port vga_x / vga_y / vga_color  out  9/8/9  registered pixel to the VGA adapter.
REQ-012 The module SHALL have port vga_write  out  1  registered write strobe to the VGA adapter.
REQ-013 The module SHALL have port owner  out  2  current burst owner index; value 3 means none.
REQ-014 The module SHALL have port busy  out  1  high while a burst is locked.

Function
REQ-015 A beat SHALL transfer on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 The block SHALL have two states: IDLE (no owner) and LOCKED (owner latched).
- In IDLE, req_ready SHALL combinationally grant one valid requester chosen by the arbitration rule.
- In IDLE, if no requester is valid, req_ready SHALL be 0.
REQ-017 If a beat transfers in IDLE with req_last = 0, the block SHALL move to LOCKED with owner = i on that edge.
REQ-018 If a beat transfers in IDLE with req_last = 1, the block SHALL stay in IDLE (single-pixel burst).
REQ-019 In LOCKED, req_ready SHALL equal req_valid[owner] only; other requesters SHALL wait regardless of priority.
REQ-020 In LOCKED, a transferred beat with req_last = 1 SHALL return the block to IDLE on that edge; the next grant is evaluated in the following cycle.
REQ-021 Latency SHALL be one cycle: a beat transferred at edge N SHALL produce vga_x/vga_y/vga_color and vga_write at edge N+1.
REQ-022 vga_write SHALL be a one-cycle pulse per accepted in-range beat; back-to-back beats SHALL give continuous writes.
REQ-023 A beat with x >= SCREEN_W or y >= SCREEN_H SHALL be accepted (handshake completes) but SHALL produce vga_write = 0; vga_x/vga_y/vga_color SHALL hold their previous values.
REQ-024 A requester deasserting req_valid mid-burst SHALL keep the lock; there is no timeout.
REQ-025 Colour SHALL pass through unmodified; no arithmetic on x/y other than the unsigned bound compares.

Reset
REQ-026 Assertion of reset SHALL immediately force state IDLE, owner = 3, busy = 0, vga_write = 0, vga_x = 0, vga_y = 0, vga_color = 0, and the round-robin pointer = 2.
REQ-027 Reset mid-burst SHALL abandon the burst with no further writes; after reset releases, arbitration restarts from IDLE.

Configuration
REQ-028 With macro VGA_ARB_ROUND_ROBIN_EN defined, IDLE arbitration SHALL be round-robin: search starts at (last granted index + 1) mod 3, and the pointer updates on every IDLE grant.
REQ-029 Without VGA_ARB_ROUND_ROBIN_EN, IDLE arbitration SHALL be fixed priority (0 > 1 > 2) and the pointer register SHALL not exist.

Structure
REQ-030 The shared package vga_pkg SHALL hold SCREEN_W/SCREEN_H defaults, X/Y/colour widths, the requester index constants (REQ_CLEAR, REQ_BRUSH, REQ_CURSOR, OWNER_NONE), and the state encoding.
REQ-031 One sub-module, vga_arb_pick, SHALL contain the combinational 3-way pick (valid vector plus start index to one-hot grant); the top module SHALL hold the state, owner, and output registers.

Verification
REQ-032 Scenario: requesters 1 and 2 each assert a single beat (last = 1) in the same cycle, fixed priority -> requester 1 is granted first, requester 2 one cycle later; vga_write is high on 2 consecutive cycles.
REQ-033 Scenario: requester 0 runs a 76800-beat clear burst while requester 2 is valid throughout -> owner = 0 and busy = 1 until the last beat, requester 2 is granted the cycle after, and exactly 76800 writes occur.
REQ-034 Scenario: requester 1 sends a beat at (320, 5) then a beat at (319, 239) -> both handshakes complete; only the second produces vga_write, with vga_x = 319 and vga_y = 239.
REQ-035 Scenario: requester 2 drops req_valid for 5 cycles mid-burst while requester 0 is valid -> requester 0 stays blocked; the burst resumes and completes under owner 2.
REQ-036 Scenario: with VGA_ARB_ROUND_ROBIN_EN defined and all three requesters continuously sending single beats -> grant order is 0, 1, 2, 0, 1, 2.
REQ-037 Scenario: assert reset during LOCKED on the beat after acceptance -> vga_write = 0 immediately, owner = 3, and no stale write occurs after release.
